// File: rtl/riscv_pkg.sv
// Shared RV32 encodings and the ALU operation bundle, used by the issue stage and the ALU.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADD     = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } alu_op_t;

  function automatic logic is_shift_funct3(input logic [2:0] f3);
    return (f3 == FUNCT3_SLL) || (f3 == FUNCT3_SRL_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_imm_gen.sv
// Combinational immediate (I / U / shamt) and legality decode for the ALU issue stage.
// Macro ALU_ISSUE_RV32M_EN makes OP with funct7=0000001 (RV32M) legal.
module alu_issue_imm_gen
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] imm,
  output logic             legal
);

  localparam int SHIFTWIDTH = $clog2(WIDTH);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       op_legal;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Register-register: the alternate funct7 only exists for SUB and SRA.
  always_comb begin
    op_legal = (f7 == FUNCT7_BASE) ||
               ((f7 == FUNCT7_ALT) && ((f3 == FUNCT3_ADD) || (f3 == FUNCT3_SRL_SRA)));
`ifdef ALU_ISSUE_RV32M_EN
    if (f7 == FUNCT7_MULDIV) op_legal = 1'b1;
`endif
  end

  always_comb begin
    imm   = '0;
    legal = 1'b0;
    case (opc)
      OP: legal = op_legal;
      OPIMM: begin
        if (is_shift_funct3(f3)) begin
          imm   = WIDTH'(instr[20 +: SHIFTWIDTH]);
          legal = (f7 == FUNCT7_BASE) || ((f3 == FUNCT3_SRL_SRA) && (f7 == FUNCT7_ALT));
        end else begin
          imm   = WIDTH'($signed(instr[31:20]));
          legal = 1'b1;
        end
      end
      LUI, AUIPC: begin
        imm   = WIDTH'($signed({instr[31:12], 12'b0}));
        legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: turns a raw RV32 instruction into a registered OP/OPIMM ALU operation.
// Macro ALU_ISSUE_RV32M_EN (see alu_issue_imm_gen) admits RV32M encodings as legal OP.
module alu_issue_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rd,
  output logic [WIDTH-1:0] pc_out,
  output logic             illegal,
  output logic [31:0]      issue_count
);

  logic [WIDTH-1:0] imm;
  logic             legal;
  logic [WIDTH-1:0] rs1_val, rs2_val;

  logic [6:0]       opcode_next, opcode_reg;
  logic [2:0]       funct3_next, funct3_reg;
  logic [6:0]       funct7_next, funct7_reg;
  logic [WIDTH-1:0] op1_next, op1_reg;
  logic [WIDTH-1:0] op2_next, op2_reg;
  logic [4:0]       rd_reg;
  logic [WIDTH-1:0] pc_reg;
  logic             illegal_reg;
  logic             valid_reg;
  logic [31:0]      count_reg;
  logic             capture, handoff;

  alu_issue_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .instr (instr),
    .imm   (imm),
    .legal (legal)
  );

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  // x0 always reads as zero regardless of what the regfile returns.
  assign rs1_val  = (rs1_addr == 5'd0) ? '0 : rs1_data;
  assign rs2_val  = (rs2_addr == 5'd0) ? '0 : rs2_data;

  always_comb begin
    opcode_next = '0;
    funct3_next = '0;
    funct7_next = '0;
    op1_next    = '0;
    op2_next    = '0;
    if (legal) begin
      case (instr[6:0])
        OP: begin
          opcode_next = OP;
          funct3_next = instr[14:12];
          funct7_next = instr[31:25];
          op1_next    = rs1_val;
          op2_next    = rs2_val;
        end
        OPIMM: begin
          opcode_next = OPIMM;
          funct3_next = instr[14:12];
          funct7_next = is_shift_funct3(instr[14:12]) ? instr[31:25] : FUNCT7_BASE;
          op1_next    = rs1_val;
          op2_next    = imm;
        end
        // Upper-immediate forms become ADDI-style operations for the ALU.
        LUI: begin
          opcode_next = OPIMM;
          funct3_next = FUNCT3_ADD;
          op2_next    = imm;
        end
        AUIPC: begin
          opcode_next = OPIMM;
          funct3_next = FUNCT3_ADD;
          op1_next    = pc;
          op2_next    = imm;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = !flush && (!valid_reg || out_ready);
  assign capture  = in_valid && in_ready;
  assign handoff  = valid_reg && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      opcode_reg  <= '0;
      funct3_reg  <= '0;
      funct7_reg  <= '0;
      op1_reg     <= '0;
      op2_reg     <= '0;
      rd_reg      <= '0;
      pc_reg      <= '0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      if (handoff) count_reg <= count_reg + 32'd1;
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (capture) begin
        valid_reg   <= 1'b1;
        opcode_reg  <= opcode_next;
        funct3_reg  <= funct3_next;
        funct7_reg  <= funct7_next;
        op1_reg     <= op1_next;
        op2_reg     <= op2_next;
        rd_reg      <= instr[11:7];
        pc_reg      <= pc;
        illegal_reg <= !legal;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_reg;
  assign opcode      = opcode_reg;
  assign funct3      = funct3_reg;
  assign funct7      = funct7_reg;
  assign op1         = op1_reg;
  assign op2         = op2_reg;
  assign rd          = rd_reg;
  assign pc_out      = pc_reg;
  assign illegal     = illegal_reg;
  assign issue_count = count_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode table, backpressure, flush, async reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] op1, op2;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] pc_out;
  logic        illegal;
  logic [31:0] issue_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_count = '0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .pc_out(pc_out),
    .illegal(illegal), .issue_count(issue_count)
  );

  typedef struct {
    string       name;
    logic [31:0] instr, pc, r1, r2;
    logic        ill;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] op1, op2;
  } vec_t;

  vec_t vecs[$];

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, illegal, opcode, funct3, funct7, rd, op1, op2, pc_out, issue_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got valid=%b op1=%h op2=%h count=%h exp all zero", out_valid, op1, op2, issue_count);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    $display("reset: out_valid=%b issue_count=%0d", out_valid, issue_count);
  endtask

  task automatic test_decode_stream();
    vecs.push_back('{"addi_neg", 32'hFFB00093, 32'h100, 32'h1234, 32'h5678, 1'b0, 7'h13, 3'd0, 7'h00, 5'd1, 32'h0, 32'hFFFFFFFB});
    vecs.push_back('{"srai", 32'h4030D113, 32'h104, 32'h80000000, 32'h0, 1'b0, 7'h13, 3'd5, 7'h20, 5'd2, 32'h80000000, 32'h3});
    vecs.push_back('{"lui", 32'h123452B7, 32'h108, 32'hDEADBEEF, 32'h0, 1'b0, 7'h13, 3'd0, 7'h00, 5'd5, 32'h0, 32'h12345000});
    vecs.push_back('{"auipc", 32'hFFFFF397, 32'h1000, 32'h55, 32'h0, 1'b0, 7'h13, 3'd0, 7'h00, 5'd7, 32'h1000, 32'hFFFFF000});
`ifdef ALU_ISSUE_RV32M_EN
    vecs.push_back('{"mul", 32'h022081B3, 32'h10C, 32'h7, 32'h9, 1'b0, 7'h33, 3'd0, 7'h01, 5'd3, 32'h7, 32'h9});
`else
    vecs.push_back('{"mul", 32'h022081B3, 32'h10C, 32'h7, 32'h9, 1'b1, 7'h00, 3'd0, 7'h00, 5'd3, 32'h0, 32'h0});
`endif
    vecs.push_back('{"sub", 32'h40208233, 32'h110, 32'h10, 32'h3, 1'b0, 7'h33, 3'd0, 7'h20, 5'd4, 32'h10, 32'h3});
    vecs.push_back('{"sll_alt", {7'h20, 5'd2, 5'd1, 3'b001, 5'd4, 7'h33}, 32'h114, 32'h10, 32'h3, 1'b1, 7'h00, 3'd0, 7'h00, 5'd4, 32'h0, 32'h0});
    vecs.push_back('{"slli_alt", {7'h20, 5'd3, 5'd1, 3'b001, 5'd6, 7'h13}, 32'h118, 32'h10, 32'h3, 1'b1, 7'h00, 3'd0, 7'h00, 5'd6, 32'h0, 32'h0});
    vecs.push_back('{"srli_31", {7'h00, 5'd31, 5'd1, 3'b101, 5'd6, 7'h13}, 32'h11C, 32'hFFFFFFFF, 32'h0, 1'b0, 7'h13, 3'd5, 7'h00, 5'd6, 32'hFFFFFFFF, 32'h1F});
    vecs.push_back('{"lw", 32'h00002183, 32'h2000, 32'h1, 32'h2, 1'b1, 7'h00, 3'd0, 7'h00, 5'd3, 32'h0, 32'h0});
    vecs.push_back('{"add_x0", {7'h00, 5'd2, 5'd0, 3'b000, 5'd8, 7'h33}, 32'h120, 32'hAAAA5555, 32'h12, 1'b0, 7'h33, 3'd0, 7'h00, 5'd8, 32'h0, 32'h12});
    vecs.push_back('{"addi_max", {12'h7FF, 5'd1, 3'b000, 5'd9, 7'h13}, 32'h124, 32'h1, 32'h0, 1'b0, 7'h13, 3'd0, 7'h00, 5'd9, 32'h1, 32'h7FF});

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      instr = vecs[i].instr; pc = vecs[i].pc; rs1_data = vecs[i].r1; rs2_data = vecs[i].r2;
      in_valid = 1'b1;
      #1;
      vectors++;
      if ({in_ready, rs1_addr, rs2_addr} !== {1'b1, vecs[i].instr[19:15], vecs[i].instr[24:20]}) begin
        miscompares++;
        $display("FAIL %s_issue got ready=%b rs1=%0d rs2=%0d exp ready=1 rs1=%0d rs2=%0d", vecs[i].name,
                 in_ready, rs1_addr, rs2_addr, vecs[i].instr[19:15], vecs[i].instr[24:20]);
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, illegal, opcode, funct3, funct7, rd} !==
          {1'b1, vecs[i].ill, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rd}) begin
        miscompares++;
        $display("FAIL %s_ctl got v=%b ill=%b opc=%h f3=%h f7=%h rd=%0d exp v=1 ill=%b opc=%h f3=%h f7=%h rd=%0d",
                 vecs[i].name, out_valid, illegal, opcode, funct3, funct7, rd,
                 vecs[i].ill, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rd);
      end
      vectors++;
      if ({op1, op2, pc_out, issue_count} !== {vecs[i].op1, vecs[i].op2, vecs[i].pc, exp_count}) begin
        miscompares++;
        $display("FAIL %s_data got op1=%h op2=%h pc=%h cnt=%0d exp op1=%h op2=%h pc=%h cnt=%0d", vecs[i].name,
                 op1, op2, pc_out, issue_count, vecs[i].op1, vecs[i].op2, vecs[i].pc, exp_count);
      end
      $display("%s: instr=%h op1=%h op2=%h opcode=%h illegal=%b", vecs[i].name, vecs[i].instr, op1, op2, opcode, illegal);
      exp_count++;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, issue_count} !== {1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL stream_drain got valid=%b cnt=%0d exp valid=0 cnt=%0d", out_valid, issue_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFB00093; pc = 32'h300; rs1_data = 32'h0;
    @(posedge clk);
    #1;
    instr = 32'h123452B7; pc = 32'h304;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_in_ready_%0d got %b exp 0", c, in_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, opcode, op1, op2, rd, pc_out, issue_count} !==
          {1'b1, 7'h13, 32'h0, 32'hFFFFFFFB, 5'd1, 32'h300, exp_count}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d got v=%b op2=%h rd=%0d pc=%h cnt=%0d exp v=1 op2=fffffffb rd=1 pc=00000300 cnt=%0d",
                 c, out_valid, op2, rd, pc_out, issue_count, exp_count);
      end
      $display("backpressure hold %0d: out_valid=%b op2=%h", c, out_valid, op2);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    exp_count++;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, op2, rd, pc_out, issue_count} !== {1'b1, 32'h12345000, 5'd5, 32'h304, exp_count}) begin
      miscompares++;
      $display("FAIL bp_release got v=%b op2=%h rd=%0d pc=%h cnt=%0d exp v=1 op2=12345000 rd=5 pc=00000304 cnt=%0d",
               out_valid, op2, rd, pc_out, issue_count, exp_count);
    end
    @(posedge clk);
    #1;
    exp_count++;
    vectors++;
    if ({out_valid, issue_count} !== {1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL bp_drain got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, issue_count, exp_count);
    end
    $display("backpressure release: issue_count=%0d", issue_count);
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFB00093; pc = 32'h400;
    @(posedge clk);
    #1;
    flush = 1'b1; instr = 32'h123452B7;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_ready got %b exp 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if ({out_valid, op2, issue_count} !== {1'b0, 32'hFFFFFFFB, exp_count}) begin
      miscompares++;
      $display("FAIL flush_held got v=%b op2=%h cnt=%0d exp v=0 op2=fffffffb cnt=%0d", out_valid, op2, issue_count, exp_count);
    end
    $display("flush held: out_valid=%b issue_count=%0d", out_valid, issue_count);
    in_valid = 1'b1; instr = 32'hFFB00093;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    vectors++;
    if ({out_valid, issue_count} !== {1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL flush_accepting got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, issue_count, exp_count);
    end
    $display("flush while out_ready: out_valid=%b issue_count=%0d", out_valid, issue_count);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h123452B7; pc = 32'h500;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, op2} !== {1'b1, 32'h12345000}) begin
      miscompares++;
      $display("FAIL rstmid_setup got v=%b op2=%h exp v=1 op2=12345000", out_valid, op2);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_count = '0;
    vectors++;
    if ({out_valid, illegal, opcode, funct3, funct7, rd, op1, op2, pc_out, issue_count} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async got v=%b op2=%h rd=%0d pc=%h cnt=%0d exp all zero", out_valid, op2, rd, pc_out, issue_count);
    end
    $display("async reset: out_valid=%b issue_count=%0d", out_valid, issue_count);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, issue_count} !== {1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL rstmid_after got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, issue_count, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_decode_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
